accum_calc_engine: RTL and testbench
====================================

Name: accum_calc_engine

Overview:
- Per-iteration compute stage, enabled by the iteration counter via `in_enableAccumCalc`.
- Each pass computes v_new = Y × v_old over an N×N signed fixed-point matrix held in Y SRAM; the v vector lives in a ping-pong V SRAM.
- Writes each v_new element, then pulses `op_accumCalcDoneFlag` so the counter can start the next iteration.
- Sits directly upstream of the iteration counter (feeds its done input, consumes its enable).

Parameters:
- N, 16: vector length / matrix dimension (power of 2, ≥2).
- DATA_W, 16: signed width of Y and v elements.
- FRAC_W, 8: fractional bits of the Y and v Q-format.
- LOG2N, 4: log2(N).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_enableAccumCalc  in  1  level enable from the iteration counter.
- op_ySramReadEn  out  1  Y SRAM read strobe.
- op_ySramReadAddr  out  2*LOG2N  Y address = row*N + col.
- in_ySramReadData  in  DATA_W  Y data; valid the cycle after the strobe.
- op_vSramReadEn  out  1  V read strobe, issued together with the Y strobe.
- op_vSramReadAddr  out  LOG2N+1  {bank, col}; bank = op_vBankSel.
- in_vSramReadData  in  DATA_W  V data; valid the cycle after the strobe.
- op_vSramWriteEn  out  1  V write strobe.
- op_vSramWriteAddr  out  LOG2N+1  {~bank, row}.
- op_vSramWriteData  out  DATA_W  result element.
- op_vBankSel  out  1  current read bank.
- op_accumCalcDoneFlag  out  1  one-cycle pass-complete pulse.

Behaviour:
- Reset (async, active-high):
  - All outputs 0, op_vBankSel = 0.
  - FSM in IDLE; row/col counters 0; accumulator 0.
- FSM states: IDLE, READ, DRAIN1, DRAIN2, WRITE, DONE, WAIT_RELEASE.
  - IDLE: if enable sampled high, set row = 0, col = 0, clear accumulator, go to READ.
  - READ: assert both read strobes at (row, col), one per cycle.
    - col increments each cycle.
    - After col = N-1 is issued, go to DRAIN1.
  - DRAIN1 → DRAIN2 → WRITE: flushes the pipeline (1-cycle SRAM latency + registered product).
  - WRITE:
    - op_vSramWriteEn = 1 for exactly one cycle.
    - Writes the saturated result to {~bank, row} and clears the accumulator.
    - If row = N-1, go to DONE.
    - Otherwise row++, col = 0, go to READ.
  - DONE:
    - op_accumCalcDoneFlag = 1 for exactly one cycle.
    - op_vBankSel toggles at the end of this cycle.
    - Go to WAIT_RELEASE.
  - WAIT_RELEASE: stay until enable is sampled low, then go to IDLE. This prevents a retrigger while the counter drops and re-raises enable.
- Pipeline, per read issued in cycle t:
  - Data arrives in t+1 and the DATA_W×DATA_W signed product is registered at the end of t+1.
  - The product is added into the accumulator at the end of t+2.
  - Accumulator width is 2*DATA_W+LOG2N; it never overflows.
- Result conversion:
  - Arithmetic right shift of the accumulator by FRAC_W (floor rounding).
  - Saturate to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Timing, with cycle 0 = enable sampled high in IDLE:
  - Row r occupies cycles r*(N+3)+1 … (r+1)*(N+3); its write is in the last of these.
  - Done pulse occurs in cycle N*(N+3)+1.
- Enable low while in READ/DRAIN/WRITE (abort):
  - Next state is IDLE; the cycle enable is seen low issues no further strobes.
  - No done pulse; op_vBankSel unchanged.
  - Rows already written stay written in the write bank.
- Enable low during DONE: the pulse still completes, then go to IDLE.
- Read and write strobes never target the same bank in the same cycle.
- Reset mid-pass: immediate return to reset values. op_vBankSel returns to 0.

Test Plan:
- N=4, FRAC_W=8, Y = identity (0x0100 on the diagonal), v bank0 = {1.0, -2.0, 0.5, 3.0} → bank1 rows 0–3 written with the same values at cycles 7, 14, 21, 28; done pulse at cycle 29; op_vBankSel = 1 afterwards.
- All Y = 0x7FFF, all v = 0x7FFF → every write = 0x7FFF (positive saturation). Negate v → every write = 0x8000.
- Enable held high for 5 cycles after done → no second pass, no strobes. Drop enable 1 cycle, re-raise → second pass reads bank1, writes bank0, done 29 cycles later, op_vBankSel = 0.
- Drop enable during row 2 READ → strobes stop that cycle; no done pulse; bank unchanged; rows 0–1 written only.
- Assert reset asynchronously mid-WRITE → write strobe and all outputs deassert without waiting for a clock edge; op_vBankSel = 0; the next enable restarts from row 0.
- Y = 0x0180 (1.5) × v = 0xFF80 (-0.5), N=4 → each row result = -3.0 = 0xFD00, checking the floor shift and signed product.

Source files
------------

// File: rtl/accum_calc_engine.sv
// One matrix-vector pass v_new = Y * v_old over ping-pong V banks.
// Strobes stop in the same cycle the iteration enable is seen low.
module accum_calc_engine #(
   parameter int N      = 16,
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int LOG2N  = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_enableAccumCalc,
   output logic                  op_ySramReadEn,
   output logic [2*LOG2N-1:0]    op_ySramReadAddr,
   input  logic [DATA_W-1:0]     in_ySramReadData,
   output logic                  op_vSramReadEn,
   output logic [LOG2N:0]        op_vSramReadAddr,
   input  logic [DATA_W-1:0]     in_vSramReadData,
   output logic                  op_vSramWriteEn,
   output logic [LOG2N:0]        op_vSramWriteAddr,
   output logic [DATA_W-1:0]     op_vSramWriteData,
   output logic                  op_vBankSel,
   output logic                  op_accumCalcDoneFlag
);

   localparam int PW = 2 * DATA_W;
   localparam int AW = 2 * DATA_W + LOG2N;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_DRAIN1,
      S_DRAIN2,
      S_WRITE,
      S_DONE,
      S_WAIT_RELEASE
   } state_t;

   state_t                state_q, state_d;
   logic [LOG2N-1:0]      row_q, row_d;
   logic [LOG2N-1:0]      col_q, col_d;
   logic                  bank_q, bank_d;
   logic                  rd_vld_q, rd_vld_d;
   logic                  prod_vld_q, prod_vld_d;
   logic signed [PW-1:0]  prod_q, prod_d;
   logic signed [AW-1:0]  acc_q, acc_d;

   logic                  en;
   logic                  rd_fire;
   logic                  wr_fire;
   logic signed [AW-1:0]  shifted;
   logic [AW-DATA_W:0]    hi_bits;
   logic [DATA_W-1:0]     sat;

   assign en      = in_enableAccumCalc;
   assign rd_fire = (state_q == S_READ) && en;
   assign wr_fire = (state_q == S_WRITE) && en;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      bank_d  = bank_q;
      unique case (state_q)
         S_IDLE: begin
            if (en) begin
               row_d   = '0;
               col_d   = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (!en) begin
               state_d = S_IDLE;
            end else begin
               col_d = col_q + LOG2N'(1);
               if (col_q == LOG2N'(N - 1)) state_d = S_DRAIN1;
            end
         end
         S_DRAIN1: state_d = en ? S_DRAIN2 : S_IDLE;
         S_DRAIN2: state_d = en ? S_WRITE : S_IDLE;
         S_WRITE: begin
            if (!en) begin
               state_d = S_IDLE;
            end else if (row_q == LOG2N'(N - 1)) begin
               state_d = S_DONE;
            end else begin
               row_d   = row_q + LOG2N'(1);
               col_d   = '0;
               state_d = S_READ;
            end
         end
         S_DONE: begin
            bank_d  = ~bank_q;
            state_d = en ? S_WAIT_RELEASE : S_IDLE;
         end
         S_WAIT_RELEASE: begin
            if (!en) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Read issued at t: data at t+1, product registered end of t+1,
   // accumulated end of t+2, so the sum is complete in WRITE.
   always_comb begin
      rd_vld_d   = rd_fire;
      prod_vld_d = rd_vld_q;
      prod_d     = $signed(in_ySramReadData) * $signed(in_vSramReadData);
      acc_d      = acc_q;
      if (state_q == S_IDLE || state_q == S_WRITE) begin
         acc_d = '0;
      end else if (prod_vld_q) begin
         acc_d = acc_q + {{LOG2N{prod_q[PW-1]}}, prod_q};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         bank_q     <= 1'b0;
         rd_vld_q   <= 1'b0;
         prod_vld_q <= 1'b0;
         prod_q     <= '0;
         acc_q      <= '0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         bank_q     <= bank_d;
         rd_vld_q   <= rd_vld_d;
         prod_vld_q <= prod_vld_d;
         prod_q     <= prod_d;
         acc_q      <= acc_d;
      end
   end

   // Floor shift back to Q-format, then clamp to the signed element range.
   assign shifted = acc_q >>> FRAC_W;
   assign hi_bits = shifted[AW-1:DATA_W-1];

   always_comb begin
      if ((&hi_bits) || !(|hi_bits)) begin
         sat = shifted[DATA_W-1:0];
      end else if (shifted[AW-1]) begin
         sat = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         sat = {1'b0, {(DATA_W-1){1'b1}}};
      end
   end

   assign op_ySramReadEn       = rd_fire;
   assign op_ySramReadAddr     = rd_fire ? {row_q, col_q} : '0;
   assign op_vSramReadEn       = rd_fire;
   assign op_vSramReadAddr     = rd_fire ? {bank_q, col_q} : '0;
   assign op_vSramWriteEn      = wr_fire;
   assign op_vSramWriteAddr    = wr_fire ? {~bank_q, row_q} : '0;
   assign op_vSramWriteData    = wr_fire ? sat : '0;
   assign op_vBankSel          = bank_q;
   assign op_accumCalcDoneFlag = (state_q == S_DONE);

endmodule

// File: tb/tb_accum_calc_engine.sv
// Directed bench for accum_calc_engine at N=4 with behavioural Y/V SRAMs.
// Pass timing, saturation, floor rounding, re-trigger, abort and reset.
module tb_accum_calc_engine;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int FW = 8;
   localparam int LG = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          en;
   logic          yen;
   logic [3:0]    yaddr;
   logic [DW-1:0] yrd;
   logic          ven;
   logic [2:0]    vraddr;
   logic [DW-1:0] vrd;
   logic          vwen;
   logic [2:0]    vwaddr;
   logic [DW-1:0] vwdata;
   logic          bsel;
   logic          done;

   always #5 clock = ~clock;

   accum_calc_engine #(.N(N), .DATA_W(DW), .FRAC_W(FW), .LOG2N(LG)) dut (
      .clock                (clock),
      .reset                (reset),
      .in_enableAccumCalc   (en),
      .op_ySramReadEn       (yen),
      .op_ySramReadAddr     (yaddr),
      .in_ySramReadData     (yrd),
      .op_vSramReadEn       (ven),
      .op_vSramReadAddr     (vraddr),
      .in_vSramReadData     (vrd),
      .op_vSramWriteEn      (vwen),
      .op_vSramWriteAddr    (vwaddr),
      .op_vSramWriteData    (vwdata),
      .op_vBankSel          (bsel),
      .op_accumCalcDoneFlag (done)
   );

   logic [DW-1:0] ymem [16];
   logic [DW-1:0] vmem [8];
   logic [DW-1:0] ld_img [8];
   logic          ld_en = 1'b0;
   int            cyc = 0;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (yen) yrd <= ymem[yaddr];
      if (ven) vrd <= vmem[vraddr];
      if (ld_en) vmem <= ld_img;
      else if (vwen) vmem[vwaddr] <= vwdata;
   end

   int            t0;
   int            wr_cyc [$];
   logic [2:0]    wr_addr [$];
   logic [DW-1:0] wr_data [$];
   int            rd_cnt;
   int            rd_last;
   int            done_cnt;
   int            done_cyc;

   always @(negedge clock) begin
      if (vwen) begin
         wr_cyc.push_back(cyc - t0);
         wr_addr.push_back(vwaddr);
         wr_data.push_back(vwdata);
      end
      if (yen) begin
         rd_cnt  = rd_cnt + 1;
         rd_last = cyc - t0;
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc - t0;
      end
   end

   typedef struct {
      logic [DW-1:0] yd;
      logic [DW-1:0] yo;
      logic [DW-1:0] v [4];
      logic [DW-1:0] e [4];
   } vec_t;

   vec_t tbl [6];
   int   checks = 0;
   int   errors = 0;
   logic exp_bank;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clr_log();
      wr_cyc.delete();
      wr_addr.delete();
      wr_data.delete();
      rd_cnt   = 0;
      rd_last  = -1;
      done_cnt = 0;
      done_cyc = -1;
   endtask

   task automatic load(int k, logic rb);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            ymem[r*N+c] = (r == c) ? tbl[k].yd : tbl[k].yo;
      for (int c = 0; c < N; c++) begin
         ld_img[{rb, 2'(c)}]  = tbl[k].v[c];
         ld_img[{~rb, 2'(c)}] = 16'hDEAD;
      end
      @(posedge clock); #1;
      ld_en = 1'b1;
      @(posedge clock); #1;
      ld_en = 1'b0;
   endtask

   task automatic start();
      @(posedge clock); #1;
      clr_log();
      en = 1'b1;
      t0 = cyc;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && done_cnt == 0; i++) @(posedge clock);
      #1;
      chk("done_seen", done_cnt, 1);
   endtask

   task automatic run_vec(int k, bit hold);
      logic rb;
      rb = exp_bank;
      load(k, rb);
      start();
      wait_done();
      chk($sformatf("v%0d_done_cyc", k), done_cyc, (N * (N + 3)) + 1);
      chk($sformatf("v%0d_nwr", k), wr_cyc.size(), N);
      for (int r = 0; r < N; r++) begin
         if (wr_cyc.size() > r) begin
            chk($sformatf("v%0d_r%0d_cyc", k, r), wr_cyc[r], (r + 1) * (N + 3));
            chk($sformatf("v%0d_r%0d_addr", k, r), wr_addr[r], {~rb, 2'(r)});
            chk($sformatf("v%0d_r%0d_data", k, r), wr_data[r], tbl[k].e[r]);
         end
      end
      if (hold) begin
         clr_log();
         repeat (5) @(posedge clock);
         #1;
         chk("hold_no_reads", rd_cnt, 0);
         chk("hold_no_writes", wr_cyc.size(), 0);
         chk("hold_no_done", done_cnt, 0);
      end
      en = 1'b0;
      exp_bank = ~exp_bank;
      chk($sformatf("v%0d_bank", k), bsel, exp_bank);
   endtask

   initial begin
      tbl[0] = '{16'h0100, 16'h0000, '{16'h0100, 16'hFE00, 16'h0080, 16'h0300},
                 '{16'h0100, 16'hFE00, 16'h0080, 16'h0300}};
      tbl[1] = '{16'h7FFF, 16'h7FFF, '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                 '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}};
      tbl[2] = '{16'h7FFF, 16'h7FFF, '{16'h8001, 16'h8001, 16'h8001, 16'h8001},
                 '{16'h8000, 16'h8000, 16'h8000, 16'h8000}};
      tbl[3] = '{16'h0180, 16'h0180, '{16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80},
                 '{16'hFD00, 16'hFD00, 16'hFD00, 16'hFD00}};
      tbl[4] = '{16'h0001, 16'h0001, '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                 '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}};
      tbl[5] = '{16'h0100, 16'h0080, '{16'h0100, 16'h0100, 16'h0100, 16'h0100},
                 '{16'h0280, 16'h0280, 16'h0280, 16'h0280}};

      reset = 1'b1;
      en    = 1'b0;
      t0    = 0;
      clr_log();
      exp_bank = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_yen", yen, 0);
      chk("rst_wen", vwen, 0);
      chk("rst_waddr", vwaddr, 0);
      chk("rst_bank", bsel, 0);
      chk("rst_done", done, 0);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("idle_yen", yen, 0);

      for (int k = 0; k < 6; k++) run_vec(k, k == 0);

      // Abort during row 2 READ.
      load(0, exp_bank);
      start();
      for (int i = 0; i < 100 && (cyc - t0) < 16; i++) begin
         @(posedge clock); #1;
      end
      en = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      chk("abort_last_rd", rd_last, 15);
      chk("abort_nwr", wr_cyc.size(), 2);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_bank", bsel, exp_bank);
      chk("abort_row0", vmem[{~exp_bank, 2'd0}], 16'h0100);
      chk("abort_row1", vmem[{~exp_bank, 2'd1}], 16'hFE00);
      chk("abort_row2", vmem[{~exp_bank, 2'd2}], 16'hDEAD);
      chk("abort_row3", vmem[{~exp_bank, 2'd3}], 16'hDEAD);

      run_vec(5, 1'b0);
      chk("pre_rst_bank", bsel, 1);

      // Asynchronous reset in the middle of the row 0 WRITE cycle.
      load(0, exp_bank);
      start();
      for (int i = 0; i < 100 && (cyc - t0) < 7; i++) begin
         @(posedge clock); #1;
      end
      chk("pre_rst_wen", vwen, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_wen", vwen, 0);
      chk("arst_wdata", vwdata, 0);
      chk("arst_bank", bsel, 0);
      chk("arst_yen", yen, 0);
      en = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      exp_bank = 1'b0;
      run_vec(3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
